// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: phase codes,
// lamp bit positions, default phase durations and the lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RED_BA   = 3'd1,
        ST_A_GREEN  = 3'd2,
        ST_A_YELLOW = 3'd3,
        ST_RED_AB   = 3'd4,
        ST_B_GREEN  = 3'd5,
        ST_B_YELLOW = 3'd6
    } phase_e;

    // Bit positions inside a per-road 3-bit lamp vector.
    localparam int GREEN_IDX  = 0;
    localparam int YELLOW_IDX = 1;
    localparam int RED_IDX    = 2;

    // Default load values; each phase lasts load value + 1 cycles.
    localparam int DEF_CNT_WIDTH   = 5;
    localparam int DEF_A_GREEN_MIN = 14;
    localparam int DEF_B_GREEN_T   = 10;
    localparam int DEF_YELLOW_T    = 2;
    localparam int DEF_ALL_RED_T   = 1;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } lamps_t;

    // Moore lamp decode: exactly one lamp per road in every phase, and any
    // unknown code falls back to both roads red.
    function automatic lamps_t decode_lamps(input phase_e s);
        lamps_t l;
        l = '0;
        case (s)
            ST_A_GREEN: begin
                l.a[GREEN_IDX] = 1'b1;
                l.b[RED_IDX]   = 1'b1;
            end
            ST_A_YELLOW: begin
                l.a[YELLOW_IDX] = 1'b1;
                l.b[RED_IDX]    = 1'b1;
            end
            ST_B_GREEN: begin
                l.a[RED_IDX]   = 1'b1;
                l.b[GREEN_IDX] = 1'b1;
            end
            ST_B_YELLOW: begin
                l.a[RED_IDX]    = 1'b1;
                l.b[YELLOW_IDX] = 1'b1;
            end
            default: begin
                l.a[RED_IDX] = 1'b1;
                l.b[RED_IDX] = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times every phase. Load wins over counting;
// the count decrements while enabled and nonzero and then holds at zero.
module phase_timer #(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 zero
);

    // Count register: load, else saturating decrement toward zero.
    // NOTE: sequential state is written only with <= so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection controller: sequences road A and road B through
// green, yellow and all-red phases using one shared phase timer, latches
// side-road and pedestrian requests, and decodes the lamps from the state.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int A_GREEN_MIN = DEF_A_GREEN_MIN,
    parameter int B_GREEN_T   = DEF_B_GREEN_T,
    parameter int YELLOW_T    = DEF_YELLOW_T,
    parameter int ALL_RED_T   = DEF_ALL_RED_T
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 req_side,
    input  logic                 req_ped,
    output logic                 a_red,
    output logic                 a_yellow,
    output logic                 a_green,
    output logic                 b_red,
    output logic                 b_yellow,
    output logic                 b_green,
    output logic                 walk,
    output logic                 ped_pending,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] count_out
);

    // The counter saturates rather than wraps, so every load must fit.
    if ((A_GREEN_MIN >= (1 << CNT_WIDTH)) || (B_GREEN_T >= (1 << CNT_WIDTH)) ||
        (YELLOW_T >= (1 << CNT_WIDTH)) || (ALL_RED_T >= (1 << CNT_WIDTH))) begin : g_bad_durations
        $error("phase duration does not fit in CNT_WIDTH bits");
    end

    phase_e                 r_state;
    phase_e                 w_state_next;
    logic                   w_load;
    logic [CNT_WIDTH-1:0]   w_load_val;
    logic [CNT_WIDTH-1:0]   w_count;
    logic                   w_zero;
    logic                   r_side_pending;
    logic                   r_ped_pending;
    logic                   r_walk_served;
    logic                   w_enter_b_green;
    logic                   w_leave_b_green;
    lamps_t                 w_lamps;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: en low forces IDLE; otherwise advance on timer expiry,
    // with A green resting until a request is pending.
    // NOTE: w_state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_next = ST_RED_BA;
                ST_RED_BA:   if (w_zero) w_state_next = ST_A_GREEN;
                ST_A_GREEN:  if (w_zero && (r_side_pending || r_ped_pending))
                                 w_state_next = ST_A_YELLOW;
                ST_A_YELLOW: if (w_zero) w_state_next = ST_RED_AB;
                ST_RED_AB:   if (w_zero) w_state_next = ST_B_GREEN;
                ST_B_GREEN:  if (w_zero) w_state_next = ST_B_YELLOW;
                ST_B_YELLOW: if (w_zero) w_state_next = ST_RED_BA;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    // Timer load value of the phase being entered; IDLE clears the counter.
    always_comb begin
        w_load_val = '0;
        case (w_state_next)
            ST_RED_BA,
            ST_RED_AB:   w_load_val = CNT_WIDTH'(ALL_RED_T);
            ST_A_GREEN:  w_load_val = CNT_WIDTH'(A_GREEN_MIN);
            ST_A_YELLOW,
            ST_B_YELLOW: w_load_val = CNT_WIDTH'(YELLOW_T);
            ST_B_GREEN:  w_load_val = CNT_WIDTH'(B_GREEN_T);
            default:     w_load_val = '0;
        endcase
    end

    // Reload on every phase change and hold cleared while disabled.
    assign w_load = (w_state_next != r_state) || !en;

    phase_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (en),
        .count    (w_count),
        .zero     (w_zero)
    );

    assign w_enter_b_green = en && (w_state_next == ST_B_GREEN) && (r_state != ST_B_GREEN);
    assign w_leave_b_green = (r_state == ST_B_GREEN) && (w_state_next != ST_B_GREEN);

    // Request latches: served on B green entry (a request on that very edge
    // counts as served), otherwise sticky in every state including disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_side_pending <= 1'b0;
            r_ped_pending  <= 1'b0;
            r_walk_served  <= 1'b0;
        end else if (w_enter_b_green) begin
            r_side_pending <= 1'b0;
            r_ped_pending  <= 1'b0;
            r_walk_served  <= r_ped_pending || req_ped;
        end else begin
            r_side_pending <= r_side_pending || req_side;
            r_ped_pending  <= r_ped_pending || req_ped;
            if (!en || w_leave_b_green) begin
                r_walk_served <= 1'b0;
            end
        end
    end

    assign w_lamps     = decode_lamps(r_state);
    assign a_red       = w_lamps.a[RED_IDX];
    assign a_yellow    = w_lamps.a[YELLOW_IDX];
    assign a_green     = w_lamps.a[GREEN_IDX];
    assign b_red       = w_lamps.b[RED_IDX];
    assign b_yellow    = w_lamps.b[YELLOW_IDX];
    assign b_green     = w_lamps.b[GREEN_IDX];
    assign walk        = (r_state == ST_B_GREEN) && r_walk_served;
    assign ped_pending = r_ped_pending;
    assign phase       = r_state;
    assign count_out   = w_count;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench: directed scenarios plus randomized requests/enable,
// compared every cycle against a table-driven phase model.
module tb_intersection_phase_scheduler;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         req_side;
    logic         req_ped;
    logic         a_red, a_yellow, a_green;
    logic         b_red, b_yellow, b_green;
    logic         walk;
    logic         ped_pending;
    logic [2:0]   phase;
    logic [W-1:0] count_out;

    intersection_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_side    (req_side),
        .req_ped     (req_ped),
        .a_red       (a_red),
        .a_yellow    (a_yellow),
        .a_green     (a_green),
        .b_red       (b_red),
        .b_yellow    (b_yellow),
        .b_green     (b_green),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase       (phase),
        .count_out   (count_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Phase table: 0 IDLE, 1 RED_BA, 2 A_GREEN, 3 A_YELLOW, 4 RED_AB,
    // 5 B_GREEN, 6 B_YELLOW. Colours: 0 red, 1 yellow, 2 green.
    int dur   [7] = '{0, 1, 14, 2, 1, 10, 2};
    int succ  [7] = '{1, 2, 3, 4, 5, 6, 1};
    int a_col [7] = '{0, 0, 2, 1, 0, 0, 0};
    int b_col [7] = '{0, 0, 0, 0, 0, 2, 1};

    int m_phase;
    int m_cnt;
    bit m_side;
    bit m_ped;
    bit m_walk;

    function automatic void model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_side  = 0;
        m_ped   = 0;
        m_walk  = 0;
    endfunction

    function automatic void model_step(input bit e, input bit s, input bit p);
        int  nxt;
        bit  enter;
        if (!e)
            nxt = 0;
        else if (m_phase == 0)
            nxt = 1;
        else if (m_cnt == 0 && (m_phase != 2 || m_side || m_ped))
            nxt = succ[m_phase];
        else
            nxt = m_phase;
        enter = e && nxt == 5 && m_phase != 5;
        if (enter) begin
            m_walk = m_ped || p;
            m_side = 0;
            m_ped  = 0;
        end else begin
            m_side = m_side || s;
            m_ped  = m_ped || p;
            if (!e || (m_phase == 5 && nxt != 5)) m_walk = 0;
        end
        if (nxt != m_phase || !e)
            m_cnt = dur[nxt];
        else if (m_cnt > 0)
            m_cnt = m_cnt - 1;
        m_phase = nxt;
    endfunction

    function automatic logic [6:0] model_lamps();
        int a, b;
        a = a_col[m_phase];
        b = b_col[m_phase];
        return {a == 0, a == 1, a == 2, b == 0, b == 1, b == 2, (m_phase == 5) && m_walk};
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".phase"}, 32'(phase), 32'(m_phase));
        check({tag, ".count"}, 32'(count_out), 32'(m_cnt));
        check({tag, ".lamps"}, 32'({a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk}),
              32'(model_lamps()));
        check({tag, ".ped_pending"}, 32'(ped_pending), 32'(m_ped));
    endtask

    // One clock: drive at negedge, model on posedge, compare 1 time unit later.
    task automatic step(input bit e, input bit s, input bit p, input string tag);
        @(negedge clk);
        en       = e;
        req_side = s;
        req_ped  = p;
        @(posedge clk);
        model_step(e, s, p);
        #1;
        compare_all(tag);
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (m_phase != target && n < budget) begin
            step(1, 0, 0, tag);
            n++;
        end
        if (m_phase != target) check({tag, ".timeout"}, 32'(m_phase), 32'(target));
    endtask

    // Counts cycles spent in A_GREEN from the current (A_GREEN) cycle onward.
    task automatic measure_a_green(input string tag);
        int len = 1;
        while (phase == 3'd2 && len < 60) begin
            step(1, 0, 0, tag);
            if (phase == 3'd2) len++;
        end
        check({tag, ".a_green_len"}, 32'(len), 32'd15);
    endtask

    // Async reset pulse strictly between clock edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        req_side = 1'b0;
        req_ped  = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        rst = 1'b0;

        // Idle approach, then rest in A_GREEN with no requests.
        for (int i = 0; i < 70; i++) step(1, 0, 0, "rest");
        check("rest.phase_a_green", 32'(phase), 32'd2);
        check("rest.count_zero", 32'(count_out), 32'd0);

        // Reset while resting in A_GREEN.
        async_reset("rst_mid_green");

        // Side request 3 cycles into A_GREEN; full cycle without walk.
        run_until(2, 10, "side.reach");
        for (int i = 0; i < 3; i++) step(1, 0, 0, "side.wait");
        step(1, 1, 0, "side.pulse");
        run_until(5, 40, "side.to_bg");
        check("side.no_walk", 32'(walk), 32'd0);
        run_until(2, 40, "side.back");

        // Pedestrian request only.
        step(1, 0, 1, "ped.pulse");
        check("ped.latched", 32'(ped_pending), 32'd1);
        run_until(5, 40, "ped.to_bg");
        check("ped.walk", 32'(walk), 32'd1);
        check("ped.cleared", 32'(ped_pending), 32'd0);
        run_until(2, 40, "ped.back");

        // Ped request exactly on the RED_AB -> B_GREEN edge.
        step(1, 1, 0, "edge.side");
        while (!(m_phase == 4 && m_cnt == 0) && n_tests < 100000) step(1, 0, 0, "edge.wait");
        step(1, 0, 1, "edge.ped");
        check("edge.walk", 32'(walk), 32'd1);
        check("edge.ped_clear", 32'(ped_pending), 32'd0);
        run_until(6, 20, "edge.to_by");
        step(1, 1, 0, "edge.side_in_by");
        run_until(2, 20, "edge.to_ag");
        measure_a_green("edge");

        // en dropped during B_GREEN with a pedestrian request pending.
        run_until(5, 40, "en.to_bg");
        step(1, 0, 0, "en.bg");
        step(0, 0, 1, "en.drop");
        check("en.idle", 32'(phase), 32'd0);
        check("en.no_walk", 32'(walk), 32'd0);
        check("en.both_red", 32'({a_red, b_red}), 32'd3);
        step(0, 0, 0, "en.low");
        step(1, 0, 0, "en.raise");
        check("en.red_ba", 32'(phase), 32'd1);
        run_until(2, 10, "en.to_ag");
        measure_a_green("en_pending");

        // Randomized enable and requests with occasional async reset.
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 250) async_reset("rand_rst");
            step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 4, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
